// File: rtl/sound_i2s_tx.sv
// I2S / left-justified serialiser for a stereo pair of signed PCM samples.
// BCLK, LRCK and SDATA are all registered outputs derived from CLK.
module sound_i2s_tx #(
    parameter int DATA_WIDTH     = 16,
    parameter int SLOT_WIDTH     = 32,
    parameter int BCLK_DIV       = 4,
    parameter int LEFT_JUSTIFIED = 0
) (
    input  logic                  RESET_n,
    input  logic                  CLK,
    input  logic [DATA_WIDTH-1:0] SOUND_L,
    input  logic [DATA_WIDTH-1:0] SOUND_R,
    input  logic                  MUTE,
    output logic                  SAMPLE_STB,
    output logic                  I2S_BCLK,
    output logic                  I2S_LRCK,
    output logic                  I2S_SDATA
);

    localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam int B_W   = $clog2(2 * SLOT_WIDTH);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int K_OFS = (LEFT_JUSTIFIED != 0) ? 0 : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [B_W-1:0]   B_LAST   = B_W'(2 * SLOT_WIDTH - 1);
    localparam logic [B_W-1:0]   B_HALF   = B_W'(SLOT_WIDTH);

    logic [DIV_W-1:0]      div_cnt;
    logic [B_W-1:0]        b;
    logic [B_W-1:0]        b_nxt;
    logic [B_W-1:0]        p_nxt;
    logic [DATA_WIDTH-1:0] hold_l;
    logic [DATA_WIDTH-1:0] hold_r;
    logic [DATA_WIDTH-1:0] hold_l_nxt;
    logic [DATA_WIDTH-1:0] hold_r_nxt;
    logic [DATA_WIDTH-1:0] word_nxt;
    logic [IDX_W-1:0]      idx_nxt;
    logic                  bclk_fall;
    logic                  frame_wrap;
    logic                  right_nxt;
    logic                  sdata_nxt;
    int                    k_nxt;

    // Everything below describes the state that takes effect at the next BCLK fall,
    // so a freshly captured sample can already drive the first data bit.
    always_comb begin
        bclk_fall  = (div_cnt == DIV_LAST) && I2S_BCLK;
        frame_wrap = (b == B_LAST);
        b_nxt      = frame_wrap ? '0 : b + B_W'(1);
        right_nxt  = (b_nxt >= B_HALF);
        p_nxt      = right_nxt ? b_nxt - B_HALF : b_nxt;
        hold_l_nxt = hold_l;
        hold_r_nxt = hold_r;
        if (frame_wrap) begin
            hold_l_nxt = MUTE ? '0 : SOUND_L;
            hold_r_nxt = MUTE ? '0 : SOUND_R;
        end
        word_nxt  = right_nxt ? hold_r_nxt : hold_l_nxt;
        k_nxt     = int'(p_nxt) - K_OFS;
        idx_nxt   = IDX_W'(DATA_WIDTH - 1 - k_nxt);
        sdata_nxt = (k_nxt >= 0 && k_nxt < DATA_WIDTH) ? word_nxt[idx_nxt] : 1'b0;
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            div_cnt    <= '0;
            b          <= B_LAST;
            hold_l     <= '0;
            hold_r     <= '0;
            SAMPLE_STB <= 1'b0;
            I2S_BCLK   <= 1'b0;
            I2S_LRCK   <= 1'b1;
            I2S_SDATA  <= 1'b0;
        end else begin
            SAMPLE_STB <= 1'b0;
            if (div_cnt == DIV_LAST) begin
                div_cnt  <= '0;
                I2S_BCLK <= ~I2S_BCLK;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (bclk_fall) begin
                b          <= b_nxt;
                hold_l     <= hold_l_nxt;
                hold_r     <= hold_r_nxt;
                I2S_LRCK   <= right_nxt;
                I2S_SDATA  <= sdata_nxt;
                SAMPLE_STB <= frame_wrap;
            end
        end
    end

endmodule

// File: tb/tb_sound_i2s_tx.sv
// Bench for sound_i2s_tx: I2S and left-justified instances against a cycle-count model
// of the frame timing.
module tb_sound_i2s_tx;

    localparam int DW   = 16;
    localparam int SW   = 32;
    localparam int DIV  = 4;
    localparam int BPER = 2 * DIV;
    localparam int NB   = 2 * SW;

    logic          CLK     = 1'b0;
    logic          RESET_n = 1'b0;
    logic          MUTE    = 1'b0;
    logic [DW-1:0] SOUND_L = '0;
    logic [DW-1:0] SOUND_R = '0;

    logic stb_i, bclk_i, lrck_i, sdata_i;
    logic stb_j, bclk_j, lrck_j, sdata_j;

    int            checks   = 0;
    int            failures = 0;
    int            t        = 0;
    logic [DW-1:0] m_l      = '0;
    logic [DW-1:0] m_r      = '0;
    logic          last_stb = 1'b0;

    sound_i2s_tx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .BCLK_DIV(DIV), .LEFT_JUSTIFIED(0)) dut_i2s (
        .RESET_n(RESET_n), .CLK(CLK), .SOUND_L(SOUND_L), .SOUND_R(SOUND_R), .MUTE(MUTE),
        .SAMPLE_STB(stb_i), .I2S_BCLK(bclk_i), .I2S_LRCK(lrck_i), .I2S_SDATA(sdata_i)
    );

    sound_i2s_tx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .BCLK_DIV(DIV), .LEFT_JUSTIFIED(1)) dut_lj (
        .RESET_n(RESET_n), .CLK(CLK), .SOUND_L(SOUND_L), .SOUND_R(SOUND_R), .MUTE(MUTE),
        .SAMPLE_STB(stb_j), .I2S_BCLK(bclk_j), .I2S_LRCK(lrck_j), .I2S_SDATA(sdata_j)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0d got=%b exp=%b", tag, t, obs, exp);
        end
    endtask

    // Serial bit expected at frame bit position b, from the slot rules.
    function automatic logic exp_sdata(input int b, input int lj);
        int            p;
        int            k;
        logic [DW-1:0] w;
        p = b % SW;
        k = (lj != 0) ? p : p - 1;
        w = (b >= SW) ? m_r : m_l;
        if (k >= 0 && k < DW) return w[DW-1-k];
        return 1'b0;
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_bclk_i"}, bclk_i, 1'b0);
        check({tag, "_lrck_i"}, lrck_i, 1'b1);
        check({tag, "_sdata_i"}, sdata_i, 1'b0);
        check({tag, "_stb_i"}, stb_i, 1'b0);
        check({tag, "_bclk_j"}, bclk_j, 1'b0);
        check({tag, "_lrck_j"}, lrck_j, 1'b1);
        check({tag, "_sdata_j"}, sdata_j, 1'b0);
        check({tag, "_stb_j"}, stb_j, 1'b0);
    endtask

    task automatic release_reset();
        RESET_n = 1'b1;
        t   = 0;
        m_l = '0;
        m_r = '0;
    endtask

    // One CLK: advance the model by elapsed cycles since reset release and compare.
    task automatic step();
        int   nf;
        int   b;
        logic stb_e;
        @(posedge CLK);
        #1;
        t++;
        nf    = t / BPER;
        b     = (nf + NB - 1) % NB;
        stb_e = (t % BPER == 0) && (nf % NB == 1);
        if (stb_e) begin
            m_l = MUTE ? '0 : SOUND_L;
            m_r = MUTE ? '0 : SOUND_R;
        end
        last_stb = stb_e;
        check("bclk_i", bclk_i, ((t / DIV) % 2) == 1);
        check("bclk_j", bclk_j, ((t / DIV) % 2) == 1);
        check("stb_i", stb_i, stb_e);
        check("stb_j", stb_j, stb_e);
        check("lrck_i", lrck_i, b >= SW);
        check("lrck_j", lrck_j, b >= SW);
        check("sdata_i", sdata_i, exp_sdata(b, 0));
        check("sdata_j", sdata_j, exp_sdata(b, 1));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to_strobe();
        last_stb = 1'b0;
        for (int i = 0; i < 4 * DIV * SW + 4 && !last_stb; i++) step();
        check("strobe_reached", stb_i, 1'b1);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        check_reset("init");

        // Power-up stream with the 8001/7FFE pattern.
        SOUND_L = 16'h8001;
        SOUND_R = 16'h7FFE;
        release_reset();
        run(BPER);
        check("first_stb_at_8", stb_i, 1'b1);
        run(1024);

        // Left-justified alignment of A5A5.
        SOUND_L = 16'hA5A5;
        SOUND_R = 16'($urandom);
        run_to_strobe();
        run(520);

        // Mid-frame input change is deferred to the next frame.
        SOUND_L = 16'h1234;
        run_to_strobe();
        run(200);
        SOUND_L = 16'hFFFF;
        run(600);

        // MUTE captured at the strobe, dropped mid-frame.
        SOUND_L = 16'($urandom) | 16'h0101;
        SOUND_R = 16'($urandom) | 16'h8080;
        MUTE    = 1'b1;
        run_to_strobe();
        run(100);
        MUTE = 1'b0;
        run(600);

        // Random samples changed at random points within frames.
        for (int n = 0; n < 16; n++) begin
            SOUND_L = 16'($urandom);
            SOUND_R = 16'($urandom);
            MUTE    = ($urandom_range(0, 7) == 0);
            run($urandom_range(40, 400));
        end
        MUTE = 1'b0;

        // Asynchronous reset at b=40, then a clean restart.
        run_to_strobe();
        run(40 * BPER);
        RESET_n = 1'b0;
        #1;
        check_reset("async_rst");
        repeat (2) @(posedge CLK);
        #1;
        check_reset("held_rst");
        SOUND_L = 16'($urandom);
        SOUND_R = 16'($urandom);
        release_reset();
        run(BPER);
        check("restart_stb_at_8", stb_i, 1'b1);
        run(600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
